// File: rtl/dispatch_allocator.sv
// Dispatch allocation stage: ROB tag / LSQ slot / RS station allocation with
// CDB operand resolution, registered one-cycle result.
// Optional: DISPATCH_LATE_FORWARD_EN forwards a CDB broadcast onto still
// unresolved output operands during the out_valid cycle.
module dispatch_allocator #(
  parameter int ROB_SIZE = 16,
  parameter int LSQ_SIZE = 8,
  parameter int RS_SIZE  = 8,
  parameter int NUM_CDB  = 2,
  parameter int DATA_W   = 32,
  parameter int TAG_W    = $clog2(ROB_SIZE + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_needs_rs,
  input  logic                        in_needs_lsq,
  input  logic [TAG_W-1:0]            in_src1_tag,
  input  logic [TAG_W-1:0]            in_src2_tag,
  input  logic [DATA_W-1:0]           in_src1_value,
  input  logic [DATA_W-1:0]           in_src2_value,
  input  logic [NUM_CDB-1:0]          cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]    cdb_tag,
  input  logic [NUM_CDB*DATA_W-1:0]   cdb_value,
  input  logic                        rob_retire,
  input  logic                        lsq_retire,
  input  logic                        rs_free_valid,
  input  logic [$clog2(RS_SIZE)-1:0]  rs_free_id,
  output logic                        out_valid,
  output logic [TAG_W-1:0]            out_rob_tag,
  output logic [$clog2(LSQ_SIZE)-1:0] out_lsq_idx,
  output logic [$clog2(RS_SIZE)-1:0]  out_station_id,
  output logic                        out_uses_rs,
  output logic                        out_uses_lsq,
  output logic [TAG_W-1:0]            out_src1_tag,
  output logic [TAG_W-1:0]            out_src2_tag,
  output logic [DATA_W-1:0]           out_src1_value,
  output logic [DATA_W-1:0]           out_src2_value,
  output logic                        rob_full,
  output logic                        lsq_full,
  output logic                        rs_full,
  output logic [$clog2(ROB_SIZE+1)-1:0] rob_count,
  output logic [$clog2(LSQ_SIZE+1)-1:0] lsq_count
);

  localparam int ROB_CW = $clog2(ROB_SIZE + 1);
  localparam int LSQ_IW = $clog2(LSQ_SIZE);
  localparam int LSQ_CW = $clog2(LSQ_SIZE + 1);
  localparam int RS_IW  = $clog2(RS_SIZE);

  localparam logic [ROB_CW-1:0] ROB_MAX  = ROB_CW'(ROB_SIZE);
  localparam logic [TAG_W-1:0]  TAG_LAST = TAG_W'(ROB_SIZE);
  localparam logic [TAG_W-1:0]  TAG_ONE  = TAG_W'(1);
  localparam logic [LSQ_CW-1:0] LSQ_MAX  = LSQ_CW'(LSQ_SIZE);
  localparam logic [LSQ_IW-1:0] LSQ_LAST = LSQ_IW'(LSQ_SIZE - 1);

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] value;
  } operand_t;

  // Allocation state
  logic [TAG_W-1:0]   rob_tail_q,  rob_tail_d;
  logic [LSQ_IW-1:0]  lsq_tail_q,  lsq_tail_d;
  logic [ROB_CW-1:0]  rob_count_q, rob_count_d;
  logic [LSQ_CW-1:0]  lsq_count_q, lsq_count_d;
  logic [RS_SIZE-1:0] rs_busy_q,   rs_busy_d;

  // Registered result
  logic               out_valid_q,   out_valid_d;
  logic [TAG_W-1:0]   out_rob_tag_q, out_rob_tag_d;
  logic [LSQ_IW-1:0]  out_lsq_idx_q, out_lsq_idx_d;
  logic [RS_IW-1:0]   out_station_q, out_station_d;
  logic               out_uses_rs_q, out_uses_rs_d;
  logic               out_uses_lsq_q, out_uses_lsq_d;
  operand_t           src1_q, src1_d;
  operand_t           src2_q, src2_d;

  logic               accept;
  logic [RS_IW-1:0]   rs_sel;
  logic               rs_found;
  operand_t           src1_out, src2_out;

  // Unresolved operand: the lowest-index matching CDB bus supplies the value.
  // An unresolved operand always carries value 0, so this also serves as the
  // late-forward path on an already registered operand.
  function automatic operand_t snoop(input operand_t op);
    operand_t r;
    logic     hit;
    r   = op;
    hit = 1'b0;
    if (op.tag != '0) begin
      r.value = '0;
      for (int unsigned b = 0; b < NUM_CDB; b++) begin
        if (!hit && cdb_valid[b] && (cdb_tag[b*TAG_W +: TAG_W] == op.tag)) begin
          r.tag   = '0;
          r.value = cdb_value[b*DATA_W +: DATA_W];
          hit     = 1'b1;
        end
      end
    end
    return r;
  endfunction

  assign rob_full = (rob_count_q == ROB_MAX);
  assign lsq_full = (lsq_count_q == LSQ_MAX);
  assign rs_full  = &rs_busy_q;
  assign in_ready = !flush && !rob_full && (!in_needs_lsq || !lsq_full) &&
                    (!in_needs_rs || !rs_full);
  assign accept   = in_valid && in_ready;

  // Lowest-index idle station from the registered bitmap
  always_comb begin
    rs_sel   = '0;
    rs_found = 1'b0;
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      if (!rs_busy_q[i] && !rs_found) begin
        rs_sel   = RS_IW'(i);
        rs_found = 1'b1;
      end
    end
  end

  // Next-state: allocation, counters, station bitmap and result registers
  always_comb begin
    rob_tail_d     = rob_tail_q;
    lsq_tail_d     = lsq_tail_q;
    rob_count_d    = rob_count_q;
    lsq_count_d    = lsq_count_q;
    rs_busy_d      = rs_busy_q;
    out_valid_d    = accept;
    out_rob_tag_d  = out_rob_tag_q;
    out_lsq_idx_d  = out_lsq_idx_q;
    out_station_d  = out_station_q;
    out_uses_rs_d  = out_uses_rs_q;
    out_uses_lsq_d = out_uses_lsq_q;
    src1_d         = src1_q;
    src2_d         = src2_q;

    if (accept) begin
      rob_tail_d     = (rob_tail_q == TAG_LAST) ? TAG_ONE : rob_tail_q + TAG_ONE;
      rob_count_d    = rob_count_d + ROB_CW'(1);
      out_rob_tag_d  = rob_tail_q;
      out_uses_rs_d  = in_needs_rs;
      out_uses_lsq_d = in_needs_lsq;
      out_lsq_idx_d  = in_needs_lsq ? lsq_tail_q : '0;
      out_station_d  = in_needs_rs ? rs_sel : '0;
      src1_d         = snoop('{tag: in_src1_tag, value: in_src1_value});
      src2_d         = snoop('{tag: in_src2_tag, value: in_src2_value});
      if (in_needs_lsq) begin
        lsq_tail_d  = (lsq_tail_q == LSQ_LAST) ? '0 : lsq_tail_q + LSQ_IW'(1);
        lsq_count_d = lsq_count_d + LSQ_CW'(1);
      end
    end
    if (rob_retire && rob_count_q != '0) rob_count_d = rob_count_d - ROB_CW'(1);
    if (lsq_retire && lsq_count_q != '0) lsq_count_d = lsq_count_d - LSQ_CW'(1);

    // Free is applied before allocation; the allocator only sees the
    // registered bitmap, so a freed slot is reusable from the next cycle.
    if (rs_free_valid) rs_busy_d[rs_free_id] = 1'b0;
    if (accept && in_needs_rs) rs_busy_d[rs_sel] = 1'b1;

    if (flush) begin
      rob_tail_d     = TAG_ONE;
      lsq_tail_d     = '0;
      rob_count_d    = '0;
      lsq_count_d    = '0;
      rs_busy_d      = '0;
      out_valid_d    = 1'b0;
      out_rob_tag_d  = '0;
      out_lsq_idx_d  = '0;
      out_station_d  = '0;
      out_uses_rs_d  = 1'b0;
      out_uses_lsq_d = 1'b0;
      src1_d         = '0;
      src2_d         = '0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      rob_tail_q     <= TAG_ONE;
      lsq_tail_q     <= '0;
      rob_count_q    <= '0;
      lsq_count_q    <= '0;
      rs_busy_q      <= '0;
      out_valid_q    <= 1'b0;
      out_rob_tag_q  <= '0;
      out_lsq_idx_q  <= '0;
      out_station_q  <= '0;
      out_uses_rs_q  <= 1'b0;
      out_uses_lsq_q <= 1'b0;
      src1_q         <= '0;
      src2_q         <= '0;
    end else begin
      rob_tail_q     <= rob_tail_d;
      lsq_tail_q     <= lsq_tail_d;
      rob_count_q    <= rob_count_d;
      lsq_count_q    <= lsq_count_d;
      rs_busy_q      <= rs_busy_d;
      out_valid_q    <= out_valid_d;
      out_rob_tag_q  <= out_rob_tag_d;
      out_lsq_idx_q  <= out_lsq_idx_d;
      out_station_q  <= out_station_d;
      out_uses_rs_q  <= out_uses_rs_d;
      out_uses_lsq_q <= out_uses_lsq_d;
      src1_q         <= src1_d;
      src2_q         <= src2_d;
    end
  end

`ifdef DISPATCH_LATE_FORWARD_EN
  // Late forward: catch a broadcast that lands in the out_valid cycle
  always_comb begin
    src1_out = src1_q;
    src2_out = src2_q;
    if (out_valid_q) begin
      src1_out = snoop(src1_q);
      src2_out = snoop(src2_q);
    end
  end
`else
  // Operands are presented straight from the registers
  always_comb begin
    src1_out = src1_q;
    src2_out = src2_q;
  end
`endif

  assign out_valid      = out_valid_q;
  assign out_rob_tag    = out_rob_tag_q;
  assign out_lsq_idx    = out_lsq_idx_q;
  assign out_station_id = out_station_q;
  assign out_uses_rs    = out_uses_rs_q;
  assign out_uses_lsq   = out_uses_lsq_q;
  assign out_src1_tag   = src1_out.tag;
  assign out_src1_value = src1_out.value;
  assign out_src2_tag   = src2_out.tag;
  assign out_src2_value = src2_out.value;
  assign rob_count      = rob_count_q;
  assign lsq_count      = lsq_count_q;

endmodule

// File: doc/dispatch_allocator.md
Name: dispatch_allocator

Overview:
- Parametrised, registered dispatch-allocation stage between decode/rename and the issue structures.
- Per accepted instruction it:
  - allocates a ROB tag, an optional LSQ slot and an optional reservation station;
  - resolves source operands against NUM_CDB common data buses;
  - presents the result one cycle later.
- Owns the ROB/LSQ tail pointers and occupancy counters and the RS busy bitmap. Supports flush.

Parameters:
- ROB_SIZE, 16, ROB entries; tags 1..ROB_SIZE, tag 0 = "no producer/value ready"
- LSQ_SIZE, 8, LSQ entries, indices 0..LSQ_SIZE-1
- RS_SIZE, 8, reservation stations, ids 0..RS_SIZE-1
- NUM_CDB, 2, number of CDB broadcast ports
- DATA_W, 32, operand width
- TAG_W, $clog2(ROB_SIZE+1), tag width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  squash all allocation state
- in_valid  in  1  instruction offered
- in_ready  out  1  instruction can be accepted this cycle
- in_needs_rs  in  1  instruction needs a reservation station
- in_needs_lsq  in  1  instruction is a load/store
- in_src1_tag, in_src2_tag  in  TAG_W each  producer tag from map table (0 = value valid)
- in_src1_value, in_src2_value  in  DATA_W each  register/ROB value
- cdb_valid  in  NUM_CDB  per-bus broadcast valid
- cdb_tag  in  NUM_CDB*TAG_W  packed broadcast tags
- cdb_value  in  NUM_CDB*DATA_W  packed broadcast values
- rob_retire  in  1  ROB head retired
- lsq_retire  in  1  LSQ head retired
- rs_free_valid  in  1  a station is released
- rs_free_id  in  $clog2(RS_SIZE)  id of the released station
- out_valid  out  1  allocation result valid (one-cycle pulse per accept)
- out_rob_tag  out  TAG_W  allocated ROB tag
- out_lsq_idx  out  $clog2(LSQ_SIZE)  allocated LSQ index (0 if unused)
- out_station_id  out  $clog2(RS_SIZE)  allocated station (0 if unused)
- out_uses_rs, out_uses_lsq  out  1 each  echo of the needs flags
- out_src1_tag, out_src2_tag  out  TAG_W each  unresolved producer tag (0 = resolved)
- out_src1_value, out_src2_value  out  DATA_W each  resolved value (0 if unresolved)
- rob_full, lsq_full, rs_full  out  1 each  occupancy flags
- rob_count  out  $clog2(ROB_SIZE+1)  ROB occupancy
- lsq_count  out  $clog2(LSQ_SIZE+1)  LSQ occupancy

Behaviour:
- Reset (sync, high):
  - rob_tail=1, lsq_tail=0, counts=0, RS bitmap=0;
  - all out_* = 0 (out_valid=0); full flags = 0.
- in_ready = !flush && !rob_full && (!in_needs_lsq || !lsq_full) && (!in_needs_rs || !rs_full). Combinational from registered state and the needs flags only, never from in_valid.
- Accept = in_valid && in_ready. Output registers load on the next edge, so latency is 1 cycle. out_valid is 0 in every cycle not following an accept.
- ROB allocation:
  - out_rob_tag = rob_tail;
  - rob_tail increments and wraps ROB_SIZE -> 1;
  - rob_full = (rob_count == ROB_SIZE).
- LSQ allocation (only if in_needs_lsq):
  - out_lsq_idx = lsq_tail;
  - lsq_tail wraps LSQ_SIZE-1 -> 0.
- Counters:
  - accept+retire in the same cycle: count unchanged;
  - retire with count 0: ignored;
  - accept never occurs when full (gated by in_ready).
- RS allocation:
  - selects the lowest-index non-busy station from the registered bitmap;
  - rs_full = all stations busy;
  - rs_free_valid clears the named bit on the next edge; freeing an idle station is a no-op;
  - a slot freed this cycle is not allocatable until the next cycle;
  - a free and an allocation of different ids in the same cycle both take effect.
- Operand resolution at accept, per source:
  - tag 0 -> value passes through;
  - otherwise compare against every cdb_valid bus; on a match, capture that cdb_value and set the output tag to 0;
  - multiple matches -> lowest bus index wins;
  - no match -> output tag = input tag, value 0.
- Flush: synchronous and dominant over accept and retire. Next state equals the reset state; in_ready = 0 during the flush cycle.
- Reset or flush asserted while out_valid is pending: out_valid is 0 on the next cycle.

Optional Feature:
- Macro: DISPATCH_LATE_FORWARD_EN
- Defined:
  - in the out_valid cycle, any out_src*_tag != 0 matching a valid CDB bus that cycle is combinationally replaced: tag 0, value = that bus value (lowest index wins);
  - closes the broadcast-during-dispatch window.
- Undefined: out_src* are pure registers. The reservation-station writer must snoop the CDB in that cycle.

Test Plan:
- Reset, then accept 3 instructions (needs_rs=1, needs_lsq=0) on consecutive cycles -> out_rob_tag 1,2,3; station ids 0,1,2; rob_count=3; out_valid one cycle after each accept.
- ROB_SIZE=16: accept 16 with no retire.
  - rob_full=1, in_ready=0.
  - Pulse rob_retire -> in_ready=1 next cycle.
  - Next accepted tag = 1 (wrap).
- Accept with src1_tag=5 while cdb_valid=2'b11, cdb_tag={5,5}, values {0xBB,0xAA} (bus1, bus0) -> out_src1_tag=0, out_src1_value=0xAA.
- Accept with src2_tag=7, no CDB match.
  - Macro defined + bus0 broadcasts tag 7, value 0x1234 during out_valid: out_src2_tag=0, out_src2_value=0x1234.
  - Macro undefined: out_src2_tag stays 7.
- Fill all 8 RS, then rs_free_id=3 together with an accept needing an RS.
  - in_ready=0 that cycle.
  - Next cycle: accept allocates station 3.
- After 5 allocations (2 with needs_lsq), assert flush together with in_valid:
  - no out_valid next cycle;
  - rob_count=0, lsq_count=0, all RS free;
  - next accept gets tag 1, lsq_idx 0, station 0.
